// File: rtl/register_file.sv
// 32 x 32-bit RV32I integer register file: two combinational read ports, one write port, x0 reads zero.
// Optional macro REGFILE_BYPASS_EN adds write-first forwarding from the write port to both read ports.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] readRegister1,
   input  logic [ADDR_WIDTH-1:0] readRegister2,
   input  logic [ADDR_WIDTH-1:0] writeRegister,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  writeEnable,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2
);

   localparam int NREGS = 2**ADDR_WIDTH;

   // Entry 0 has no flop; only x1..x(N-1) are storage.
   logic [DATA_WIDTH-1:0] regs_q  [1:NREGS-1];
   logic [DATA_WIDTH-1:0] rd_view [0:NREGS-1];
   logic [NREGS-1:1]      we_dec;

   always_comb begin
      we_dec = '0;
      for (int i = 1; i < NREGS; i++)
         we_dec[i] = writeEnable && (writeRegister == ADDR_WIDTH'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++)
            if (we_dec[i]) regs_q[i] <= writeData;
      end
   end

   always_comb begin
      rd_view[0] = '0;
      for (int i = 1; i < NREGS; i++) rd_view[i] = regs_q[i];
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_en;
   assign fwd_en = rst_n && writeEnable && (writeRegister != '0);

   assign readData1 = (fwd_en && readRegister1 == writeRegister) ? writeData : rd_view[readRegister1];
   assign readData2 = (fwd_en && readRegister2 == writeRegister) ? writeData : rd_view[readRegister2];
`else
   assign readData1 = rd_view[readRegister1];
   assign readData2 = rd_view[readRegister2];
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus randomized traffic against an array model.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  readRegister1, readRegister2, writeRegister;
   logic [31:0] writeData;
   logic        writeEnable;
   logic [31:0] readData1, readData2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl [32];

   always #5 clk = ~clk;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .readRegister1(readRegister1), .readRegister2(readRegister2),
      .writeRegister(writeRegister), .writeData(writeData),
      .writeEnable(writeEnable),
      .readData1(readData1), .readData2(readData2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Expected read value given the current model and the current write-port inputs.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (rst_n && writeEnable && writeRegister == a) return writeData;
`endif
      return mdl[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   // Present a write on a falling edge, let one rising edge take it, then drop the strobe.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
      @(negedge clk);
      writeRegister = a; writeData = d; writeEnable = en;
      @(posedge clk); #1;
      if (en && a != 0 && rst_n) mdl[a] = d;
      writeEnable = 1'b0;
   endtask

   task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
      readRegister1 = a1; readRegister2 = a2; #1;
      chk({tag, "_rd1"}, readData1, exp_rd(a1));
      chk({tag, "_rd2"}, readData2, exp_rd(a2));
   endtask

   initial begin
      rst_n = 1'b0; writeEnable = 1'b0; writeRegister = '0; writeData = '0;
      readRegister1 = '0; readRegister2 = '0;
      clear_model();

      // Reset state: every index reads zero on both ports.
      #2;
      for (int i = 0; i < 32; i++) begin
         readRegister1 = 5'(i); readRegister2 = 5'(31 - i); #1;
         chk("rst_rd1", readData1, 32'h0);
         chk("rst_rd2", readData2, 32'h0);
      end
      // Writes ignored while held in reset, forwarding suppressed too.
      @(negedge clk);
      writeEnable = 1'b1; writeRegister = 5'd9; writeData = 32'hCAFEF00D;
      readRegister1 = 5'd9; #1;
      chk("rst_nofwd", readData1, 32'h0);
      @(posedge clk); #1;
      chk("rst_nowr", readData1, 32'h0);
      writeEnable = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Basic write then read on both ports.
      do_write(5'd5, 32'hDEADBEEF, 1'b1);
      readRegister1 = 5'd5; readRegister2 = 5'd5; #1;
      chk("x5_rd1", readData1, 32'hDEADBEEF);
      chk("x5_rd2", readData2, 32'hDEADBEEF);
      do_write(5'd5, 32'h12345678, 1'b0);
      readRegister1 = 5'd5; #1;
      chk("x5_we0", readData1, 32'hDEADBEEF);

      // x0 discard, boundaries x1/x31, untouched x2.
      do_write(5'd0, 32'hFFFFFFFF, 1'b1);
      readRegister1 = 5'd0; #1;
      chk("x0_zero", readData1, 32'h0);
      do_write(5'd31, 32'hA5A5A5A5, 1'b1);
      do_write(5'd1, 32'h00000001, 1'b1);
      readRegister1 = 5'd31; readRegister2 = 5'd1; #1;
      chk("x31", readData1, 32'hA5A5A5A5);
      chk("x1",  readData2, 32'h00000001);
      readRegister1 = 5'd2; #1;
      chk("x2", readData1, 32'h0);

      // Same-cycle write/read of x7.
      do_write(5'd7, 32'h22222222, 1'b1);
      @(negedge clk);
      writeEnable = 1'b1; writeRegister = 5'd7; writeData = 32'h11111111;
      readRegister1 = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
      chk("x7_pre", readData1, 32'h11111111);
`else
      chk("x7_pre", readData1, 32'h22222222);
`endif
      @(posedge clk); #1;
      writeEnable = 1'b0; mdl[7] = 32'h11111111; #1;
      chk("x7_post", readData1, 32'h11111111);

      // Fill x1..x31 and read mirrored pairs to expose aliasing.
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101, 1'b1);
      for (int i = 1; i < 32; i++) begin
         readRegister1 = 5'(i); readRegister2 = 5'(32 - i); #1;
         chk("fill_rd1", readData1, 32'(i) * 32'h01010101);
         chk("fill_rd2", readData2, 32'(32 - i) * 32'h01010101);
      end

      // Randomized traffic; reads checked before each edge against the model.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         writeEnable   = ($urandom_range(0, 3) != 0);
         writeRegister = 5'($urandom_range(0, 31));
         writeData     = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            readRegister1 = writeRegister; readRegister2 = writeRegister;
         end else begin
            readRegister1 = 5'($urandom_range(0, 31));
            readRegister2 = 5'($urandom_range(0, 31));
         end
         #1;
         chk("rnd_rd1", readData1, exp_rd(readRegister1));
         chk("rnd_rd2", readData2, exp_rd(readRegister2));
         @(posedge clk); #1;
         if (writeEnable && writeRegister != 0) mdl[writeRegister] = writeData;
      end
      writeEnable = 1'b0;
      read_pair("rnd_end", 5'd3, 5'd30);

      // Async reset mid-cycle with a pending write: reads clear at once, write is lost.
      @(negedge clk);
      writeEnable = 1'b1; writeRegister = 5'd3; writeData = 32'h5A5A5A5A;
      readRegister1 = 5'd31; readRegister2 = 5'd1;
      #1 rst_n = 1'b0; #1;
      clear_model();
      chk("arst_rd1", readData1, 32'h0);
      chk("arst_rd2", readData2, 32'h0);
      @(posedge clk); #1;
      writeEnable = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      readRegister1 = 5'd3; #1;
      chk("arst_lost", readData1, 32'h0);
      // First write right after release lands.
      do_write(5'd12, 32'h0BADC0DE, 1'b1);
      read_pair("post_rst", 5'd12, 5'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file of the single-cycle RISC-V core: 32 x 32-bit general-purpose registers (x0..x31).
- Two combinational read ports feed the ALU operands (rs1/rs2).
- One synchronous write port takes the ALU result for rd.
- x0 is hardwired to zero, per RV32I.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH

Ports:
clk  input  1  system clock; all writes occur on its rising edge
rst_n  input  1  asynchronous active-low reset; clears all registers
readRegister1  input  ADDR_WIDTH  read port 1 index (rs1)
readRegister2  input  ADDR_WIDTH  read port 2 index (rs2)
writeRegister  input  ADDR_WIDTH  write index (rd)
writeData  input  DATA_WIDTH  data to write
writeEnable  input  1  write strobe, active high, sampled at posedge clk
readData1  output  DATA_WIDTH  contents of register readRegister1
readData2  output  DATA_WIDTH  contents of register readRegister2

Behaviour:
- Storage: 2**ADDR_WIDTH entries of DATA_WIDTH bits. Entry 0 is not a storage element: it always reads 0.
- Reset:
  - rst_n low forces every entry to 0 immediately, with no clock edge needed.
  - While rst_n is low, readData1 and readData2 read 0 and writes are ignored.
  - Release is synchronous in effect: the first write can occur on the first posedge clk with rst_n high.
- Write:
  - On posedge clk with rst_n=1, writeEnable=1 and writeRegister!=0: entry[writeRegister] <= writeData.
  - writeRegister==0 is silently discarded.
  - writeEnable=0 leaves all entries unchanged.
- Read:
  - Purely combinational: readData1 = (readRegister1==0) ? 0 : entry[readRegister1]; readData2 likewise.
  - Zero latency: output follows an address change within the same cycle.
- Read/write to the same index in the same cycle (default build):
  - Read returns the old value until the edge, then the new value.
  - No write-to-read bypass.
- Both read ports may address the same register; both return identical data.
- Reset asserted mid-cycle while a write is pending: reset wins and the write is lost.
- No X propagation: every entry has a defined value after reset.
- No other state, outputs or handshakes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-first forwarding on both read ports.
  - If writeEnable=1, writeRegister!=0 and readRegisterN==writeRegister, readDataN = writeData combinationally in the same cycle.
  - x0 is still always 0.
  - Forwarding is suppressed while rst_n=0.
- Not defined: reads return stored contents only, as in Behaviour.

Test Plan:
- Reset, then read all 32 indices on both ports -> every read returns 0x00000000. Assert rst_n low mid-run after writes -> reads return 0 immediately, before any clock edge.
- Write 0xDEADBEEF to x5 (writeEnable=1, one edge), then read rs1=5, rs2=5 -> both 0xDEADBEEF. With writeEnable=0 and writeData=0x12345678 to x5 -> x5 still 0xDEADBEEF.
- Write 0xFFFFFFFF to x0 -> readData1 with rs1=0 stays 0x00000000. Write x31=0xA5A5A5A5 and x1=0x00000001 -> reads of x31, x1 and x2 return 0xA5A5A5A5, 0x00000001 and 0x00000000 respectively.
- Same-cycle write x7=0x11111111 while reading rs1=7 (x7 previously 0x22222222):
  - default build -> 0x22222222 before the edge, 0x11111111 after.
  - with REGFILE_BYPASS_EN -> 0x11111111 before the edge.
- Fill x1..x31 with value = index*0x01010101, then read pairs (rs1=i, rs2=32-i) -> each port returns its own index's value, and no entry is aliased.
